// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator types (numbers, buttons, ALU ops, controller states) and helpers.
// num_t holds decimal digits left-aligned: significand[NUM_DIGITS-1] is the first digit entered.
package calc_pkg;

    localparam int NUM_DIGITS = 8;

    typedef struct packed {
        logic                       neg;
        logic [3:0]                 len;
        logic [NUM_DIGITS-1:0][3:0] significand;
    } num_t;

    typedef enum logic [4:0] {
        B_0, B_1, B_2, B_3, B_4, B_5, B_6, B_7, B_8, B_9,
        B_ADD, B_SUB, B_MUL, B_DIV, B_EQ,
        B_MEM_STORE, B_MEM_RECALL, B_MEM_CLEAR, B_MEM_ADD, B_CLEAR
    } button_t;

    typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    typedef enum logic [2:0] {
        S_IDLE = '0, S_DECODE, S_ALU_REQ, S_ALU_WAIT, S_WRITEBACK
    } ctrl_state_e;

    function automatic num_t num_from_digit(logic [3:0] d);
        num_t n = '0;
        n.len = 4'd1;
        n.significand[NUM_DIGITS-1] = d;
        return n;
    endfunction

    // Digits beyond the significand width are silently dropped.
    function automatic num_t num_append_digit(num_t n, logic [3:0] d);
        num_t r = n;
        if (n.len < 4'(NUM_DIGITS)) begin
            r.significand[3'(NUM_DIGITS-1) - n.len[2:0]] = d;
            r.len = n.len + 4'd1;
        end
        return r;
    endfunction

    function automatic op_t button_op(button_t b);
        return b == B_ADD ? OP_ADD : b == B_SUB ? OP_SUB :
               b == B_MUL ? OP_MUL : b == B_DIV ? OP_DIV : OP_NONE;
    endfunction

endpackage

// File: rtl/calc_mem_bank.sv
// calc_mem_bank: NUM_MEM calculator memory slots, one shared read/write address,
// asynchronous read, all slots cleared by reset.
module calc_mem_bank
    import calc_pkg::*;
#(
    parameter int NUM_MEM = 4,
    parameter int SEL_W   = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [SEL_W-1:0] addr_i,
    input  num_t             wdata_i,
    output num_t             rdata_o
);

    num_t mem_q [NUM_MEM];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_MEM; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/calc_controller_mem.sv
// calc_controller_mem: calculator sequencer decoding one button event at a time, with
// memory slots, chained operators, repeat-equals and an ALU watchdog.
module calc_controller_mem
    import calc_pkg::*;
#(
    parameter  int NUM_MEM     = 4,
    parameter  int ALU_TIMEOUT = 64,
    localparam int MEM_SEL_W   = NUM_MEM > 1 ? $clog2(NUM_MEM) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  button_t              active_button_i,
    input  logic                 new_input_i,
    input  logic [MEM_SEL_W-1:0] mem_sel_i,
    output logic                 busy_o,
    output logic                 dropped_o,
    output logic                 error_o,
    output logic                 display_we_o,
    output num_t                 display_wdata_o,
    input  num_t                 display_rdata_i,
    output logic                 upper_we_o,
    output num_t                 upper_wdata_o,
    input  num_t                 upper_rdata_i,
    output num_t                 alu_left_o,
    output num_t                 alu_right_o,
    output op_t                  alu_op_o,
    output logic                 alu_in_valid_o,
    input  logic                 alu_in_ready_i,
    input  num_t                 alu_result_i,
    input  logic                 alu_out_valid_i,
    output logic                 alu_out_ready_o
);

    localparam int WD_W = $clog2(ALU_TIMEOUT) + 1;

    ctrl_state_e          state_q, state_d;
    button_t              btn_q, btn_d;
    logic [MEM_SEL_W-1:0] sel_q, sel_d;
    num_t                 acc_q, acc_d, left_q, left_d, right_q, right_d, res_q, res_d;
    op_t                  pend_q, pend_d, op_q, op_d;
    logic                 fresh_q, fresh_d, err_q, err_d, to_mem_q, to_mem_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 mem_we, tmo;
    num_t                 mem_wdata, mem_rdata;

    calc_mem_bank #(.NUM_MEM(NUM_MEM), .SEL_W(MEM_SEL_W)) u_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (mem_we),
        .addr_i  (sel_q),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign tmo = (state_q == S_ALU_REQ || state_q == S_ALU_WAIT) && wd_q == WD_W'(ALU_TIMEOUT - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            btn_q    <= B_0;
            sel_q    <= '0;
            acc_q    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            res_q    <= '0;
            pend_q   <= OP_NONE;
            op_q     <= OP_NONE;
            fresh_q  <= 1'b1;
            err_q    <= 1'b0;
            to_mem_q <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            btn_q    <= btn_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            left_q   <= left_d;
            right_q  <= right_d;
            res_q    <= res_d;
            pend_q   <= pend_d;
            op_q     <= op_d;
            fresh_q  <= fresh_d;
            err_q    <= err_d;
            to_mem_q <= to_mem_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        btn_d           = btn_q;
        sel_d           = sel_q;
        acc_d           = acc_q;
        left_d          = left_q;
        right_d         = right_q;
        res_d           = res_q;
        pend_d          = pend_q;
        op_d            = op_q;
        fresh_d         = fresh_q;
        err_d           = err_q;
        to_mem_d        = to_mem_q;
        wd_d            = wd_q;
        display_we_o    = 1'b0;
        display_wdata_o = '0;
        upper_we_o      = 1'b0;
        upper_wdata_o   = '0;
        mem_we          = 1'b0;
        mem_wdata       = '0;
        case (state_q)
            S_IDLE: if (new_input_i) begin
                btn_d   = active_button_i;
                sel_d   = mem_sel_i;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d  = S_IDLE;
                wd_d     = '0;
                to_mem_d = 1'b0;
                if (!err_q || btn_q == B_CLEAR) begin
                    case (btn_q)
                        B_MEM_STORE: begin
                            mem_we    = 1'b1;
                            mem_wdata = display_rdata_i;
                        end
                        B_MEM_CLEAR: mem_we = 1'b1;
                        B_MEM_RECALL: begin
                            display_we_o    = 1'b1;
                            display_wdata_o = mem_rdata;
                            fresh_d         = 1'b1;
                        end
                        B_CLEAR: begin
                            display_we_o = 1'b1;
                            upper_we_o   = 1'b1;
                            acc_d        = '0;
                            pend_d       = OP_NONE;
                            err_d        = 1'b0;
                            fresh_d      = 1'b1;
                        end
                        B_ADD, B_SUB, B_MUL, B_DIV: begin
                            if (pend_q != OP_NONE && !fresh_q) begin
                                left_d  = acc_q;
                                right_d = display_rdata_i;
                                op_d    = pend_q;
                                state_d = S_ALU_REQ;
                            end else begin
                                acc_d   = display_rdata_i;
                                pend_d  = button_op(btn_q);
                                fresh_d = 1'b1;
                            end
                        end
                        // Repeat-equals reuses the right operand saved in upper.
                        B_EQ: if (pend_q != OP_NONE) begin
                            left_d        = fresh_q ? display_rdata_i : acc_q;
                            right_d       = fresh_q ? upper_rdata_i : display_rdata_i;
                            op_d          = pend_q;
                            upper_we_o    = !fresh_q;
                            upper_wdata_o = fresh_q ? '0 : display_rdata_i;
                            state_d       = S_ALU_REQ;
                        end
                        B_MEM_ADD: begin
                            left_d   = mem_rdata;
                            right_d  = display_rdata_i;
                            op_d     = OP_ADD;
                            to_mem_d = 1'b1;
                            state_d  = S_ALU_REQ;
                        end
                        default: begin
                            display_we_o    = 1'b1;
                            display_wdata_o = fresh_q ? num_from_digit(4'(btn_q))
                                                      : num_append_digit(display_rdata_i, 4'(btn_q));
                            fresh_d         = 1'b0;
                        end
                    endcase
                end
            end
            S_ALU_REQ: begin
                wd_d    = wd_q + 1'b1;
                state_d = alu_in_ready_i ? S_ALU_WAIT : S_ALU_REQ;
            end
            S_ALU_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (alu_out_valid_i) begin
                    res_d   = alu_result_i;
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                state_d = S_IDLE;
                if (to_mem_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = res_q;
                end else begin
                    display_we_o    = 1'b1;
                    display_wdata_o = res_q;
                    acc_d           = res_q;
                    fresh_d         = 1'b1;
                    pend_d          = btn_q == B_EQ ? pend_q : button_op(btn_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Watchdog abort overrides the handshake; acc, pending and memory are left alone.
        if (tmo) begin
            err_d           = 1'b1;
            display_we_o    = 1'b1;
            display_wdata_o = '0;
            res_d           = res_q;
            state_d         = S_IDLE;
        end
    end

    always_comb begin
        busy_o          = state_q != S_IDLE;
        dropped_o       = new_input_i && state_q != S_IDLE;
        error_o         = err_q;
        alu_left_o      = left_q;
        alu_right_o     = right_q;
        alu_op_o        = op_q;
        alu_in_valid_o  = state_q == S_ALU_REQ && !tmo;
        alu_out_ready_o = state_q == S_ALU_WAIT && !tmo;
    end

endmodule

// File: tb/tb_calc_controller_mem.sv
// tb_calc_controller_mem: table-driven button sequences against a behavioural ALU and
// display/upper registers, plus hand-written watchdog, drop and mid-op reset sequences.
module tb_calc_controller_mem;
    import calc_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    button_t btn = B_0;
    logic    new_input = 1'b0;
    logic [1:0] mem_sel = '0;
    logic    busy, dropped, error;
    logic    display_we, upper_we;
    num_t    display_wdata, upper_wdata;
    num_t    disp = '0, upper = '0;
    num_t    alu_left, alu_right, alu_result;
    op_t     alu_op;
    logic    alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready;

    int checks = 0;
    int passes = 0;
    logic stall = 1'b0;
    logic have;
    int   cnt;

    always #5 clk = ~clk;

    calc_controller_mem dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .active_button_i (btn),
        .new_input_i     (new_input),
        .mem_sel_i       (mem_sel),
        .busy_o          (busy),
        .dropped_o       (dropped),
        .error_o         (error),
        .display_we_o    (display_we),
        .display_wdata_o (display_wdata),
        .display_rdata_i (disp),
        .upper_we_o      (upper_we),
        .upper_wdata_o   (upper_wdata),
        .upper_rdata_i   (upper),
        .alu_left_o      (alu_left),
        .alu_right_o     (alu_right),
        .alu_op_o        (alu_op),
        .alu_in_valid_o  (alu_in_valid),
        .alu_in_ready_i  (alu_in_ready),
        .alu_result_i    (alu_result),
        .alu_out_valid_i (alu_out_valid),
        .alu_out_ready_o (alu_out_ready)
    );

    function automatic int to_int(num_t n);
        int v = 0;
        for (int i = 0; i < int'(n.len) && i < 8; i++) v = v * 10 + int'(n.significand[7-i]);
        return n.neg ? -v : v;
    endfunction

    function automatic num_t from_int(int v);
        num_t r = '0;
        int   digs[8];
        int   a = v < 0 ? -v : v;
        int   n = 0;
        do begin
            digs[n] = a % 10;
            a = a / 10;
            n++;
        end while (a != 0 && n < 8);
        r.neg = v < 0;
        r.len = 4'(n);
        for (int i = 0; i < n; i++) r.significand[7-i] = 4'(digs[n-1-i]);
        return r;
    endfunction

    function automatic int alu_calc(int l, int r, op_t op);
        return op == OP_ADD ? l + r : op == OP_SUB ? l - r : op == OP_MUL ? l * r :
               op == OP_DIV ? (r == 0 ? 0 : l / r) : 0;
    endfunction

    // External display/upper registers (not reset: they belong to the display block)
    always_ff @(posedge clk) begin
        if (display_we) disp <= display_wdata;
        if (upper_we) upper <= upper_wdata;
    end

    // Behavioural ALU: accepts when idle, answers after a 3-cycle latency
    assign alu_in_ready  = !stall && !have;
    assign alu_out_valid = have && cnt == 0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have       <= 1'b0;
            cnt        <= 0;
            alu_result <= '0;
        end else if (alu_in_valid && alu_in_ready) begin
            have       <= 1'b1;
            cnt        <= 3;
            alu_result <= from_int(alu_calc(to_int(alu_left), to_int(alu_right), alu_op));
        end else if (have && cnt != 0) begin
            cnt <= cnt - 1;
        end else if (alu_out_valid && alu_out_ready) begin
            have <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            $display("FAIL busy_bound: still busy after %0d cycles, expected idle", cyc);
        end
    endtask

    task automatic strobe(input button_t b, input logic [1:0] s);
        @(negedge clk);
        btn       = b;
        mem_sel   = s;
        new_input = 1'b1;
        @(negedge clk);
        new_input = 1'b0;
    endtask

    task automatic press(input button_t b, input logic [1:0] s, output int cyc);
        strobe(b, s);
        wait_idle(cyc);
    endtask

    task automatic wait_alu_wait();
        int n = 0;
        while (!alu_out_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("reach_alu_wait", int'(alu_out_ready), 1);
    endtask

    typedef struct {
        button_t    b;
        logic [1:0] s;
        int         d;
        int         u;
    } vec_t;

    vec_t vt[$];

    initial begin
        int cyc;
        vt = '{
            '{B_1, 0, 1, 0}, '{B_ADD, 0, 1, 0}, '{B_1, 0, 1, 0},
            '{B_EQ, 0, 2, 1}, '{B_EQ, 0, 3, 1}, '{B_EQ, 0, 4, 1},
            '{B_CLEAR, 0, 0, 0},
            '{B_2, 0, 2, 0}, '{B_ADD, 0, 2, 0}, '{B_3, 0, 3, 0},
            '{B_ADD, 0, 5, 0}, '{B_4, 0, 4, 0}, '{B_EQ, 0, 9, 4},
            '{B_CLEAR, 0, 0, 0},
            '{B_5, 0, 5, 0}, '{B_MEM_STORE, 0, 5, 0}, '{B_CLEAR, 0, 0, 0},
            '{B_MEM_RECALL, 0, 5, 0}, '{B_MEM_ADD, 0, 5, 0}, '{B_MEM_RECALL, 0, 10, 0},
            '{B_8, 0, 8, 0}, '{B_MEM_STORE, 1, 8, 0}, '{B_CLEAR, 0, 0, 0},
            '{B_MEM_RECALL, 1, 8, 0}, '{B_MEM_RECALL, 0, 10, 0},
            '{B_CLEAR, 0, 0, 0},
            '{B_1, 0, 1, 0}, '{B_2, 0, 12, 0}, '{B_3, 0, 123, 0},
            '{B_SUB, 0, 123, 0}, '{B_2, 0, 2, 0}, '{B_0, 0, 20, 0},
            '{B_EQ, 0, 103, 20}, '{B_EQ, 0, 83, 20},
            '{B_CLEAR, 0, 0, 0}, '{B_6, 0, 6, 0}, '{B_EQ, 0, 6, 0}
        };

        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(error), 0);
        check("rst_in_valid", int'(alu_in_valid), 0);
        check("rst_display_we", int'(display_we), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            press(vt[i].b, vt[i].s, cyc);
            check($sformatf("vec%0d_display", i), to_int(disp), vt[i].d);
            check($sformatf("vec%0d_upper", i), to_int(upper), vt[i].u);
        end

        // Strobe while waiting on the ALU is dropped and leaves the result alone
        press(B_CLEAR, 0, cyc);
        press(B_2, 0, cyc);
        press(B_ADD, 0, cyc);
        press(B_3, 0, cyc);
        strobe(B_EQ, 0);
        wait_alu_wait();
        btn       = B_9;
        new_input = 1'b1;
        #1;
        check("dropped_pulse", int'(dropped), 1);
        @(negedge clk);
        new_input = 1'b0;
        #1;
        check("dropped_clear", int'(dropped), 0);
        wait_idle(cyc);
        check("drop_result", to_int(disp), 5);

        // Watchdog: ALU never accepts
        press(B_CLEAR, 0, cyc);
        press(B_7, 0, cyc);
        press(B_ADD, 0, cyc);
        press(B_1, 0, cyc);
        stall = 1'b1;
        press(B_EQ, 0, cyc);
        check("wd_busy_cycles", cyc, 65);
        check("wd_error", int'(error), 1);
        check("wd_display", to_int(disp), 0);
        check("wd_in_valid", int'(alu_in_valid), 0);
        stall = 1'b0;
        press(B_7, 0, cyc);
        check("err_ignores_digit", to_int(disp), 0);
        check("err_sticky", int'(error), 1);
        press(B_CLEAR, 0, cyc);
        check("clear_error", int'(error), 0);
        press(B_7, 0, cyc);
        check("after_clear_digit", to_int(disp), 7);

        // Reset in the middle of an ALU wait
        press(B_CLEAR, 0, cyc);
        press(B_2, 0, cyc);
        press(B_ADD, 0, cyc);
        press(B_3, 0, cyc);
        strobe(B_EQ, 0);
        wait_alu_wait();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_out_ready", int'(alu_out_ready), 0);
        check("mid_rst_in_valid", int'(alu_in_valid), 0);
        check("mid_rst_left_zero", int'(alu_left != '0), 0);
        check("mid_rst_display_we", int'(display_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        press(B_MEM_RECALL, 0, cyc);
        check("mid_rst_mem_slot0", to_int(disp), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
